i2s_codec_master: RTL and testbench
===================================

Name: i2s_codec_master

Overview:
- Codec-side end of the I2S serial data port; behaves as the ADAU1761 serial port does in master mode.
- Generates BCLK and LRCLK from clk_48.
- Shifts ADC-direction samples out on the data line and captures DAC-direction samples from the data line.
- Drives the FPGA-side I2S slave data interface in the bench, and stands in as a codec model or a loopback master during bring-up.

Parameters:
- HALF_BCLK, 8: clk_48 cycles per BCLK half-period. BCLK = 48 MHz / (2*HALF_BCLK). Minimum 2.
- DATA_WIDTH, 24: audio sample width in bits.
- SLOT_BITS, 32: BCLK cycles per channel slot. Must be >= DATA_WIDTH+1. Frame = 2*SLOT_BITS BCLK cycles.

Ports:
- clk_48  in  1: system clock, 48 MHz.
- reset  in  1: synchronous, active-high.
- enable  in  1: run the serial clocks; sampled every cycle.
- tx_l  in  DATA_WIDTH: left sample to transmit (codec ADC direction).
- tx_r  in  DATA_WIDTH: right sample to transmit.
- sample_req  out  1: one-cycle pulse; tx_l/tx_r captured this cycle.
- rx_l  out  DATA_WIDTH: last complete left sample received.
- rx_r  out  DATA_WIDTH: last complete right sample received.
- rx_valid  out  1: one-cycle pulse; rx_l/rx_r updated this cycle.
- i2s_bclk  out  1: bit clock.
- i2s_lr  out  1: word clock. 0 = left slot, 1 = right slot.
- i2s_sdata_out  out  1: serial data, codec to FPGA.
- i2s_sdata_in  in  1: serial data, FPGA to codec.

Behaviour:
- Reset values:
  - i2s_bclk=0, i2s_lr=1, i2s_sdata_out=0.
  - sample_req=0, rx_valid=0, rx_l=0, rx_r=0.
  - half_cnt=0, bit_cnt=2*SLOT_BITS-1.
  - Shift registers cleared.
- Clock divider: while running, half_cnt counts 0..HALF_BCLK-1. At terminal count it wraps and i2s_bclk toggles. All outputs are registered on clk_48.
- Falling edge (bclk toggling 1->0), also the first toggle after idle:
  - bit_cnt increments and wraps at 2*SLOT_BITS-1 -> 0.
  - pos = bit_cnt mod SLOT_BITS.
  - i2s_lr = (bit_cnt >= SLOT_BITS).
  - All are updated in the same clk_48 cycle as the bclk transition.
- Frame start (bit_cnt wraps to 0):
  - tx_l and tx_r are loaded into the shift registers.
  - sample_req pulses for exactly that cycle.
  - tx inputs changing at any other time do not affect the frame in flight.
- Transmit timing (I2S one-bit delay):
  - i2s_sdata_out changes only on falling edges.
  - At pos 1..DATA_WIDTH it carries the slot's sample MSB first: bit DATA_WIDTH-pos at pos.
  - At pos 0 and pos > DATA_WIDTH it drives 0.
  - The left sample uses the left slot; the right sample uses the right slot.
- Receive:
  - i2s_sdata_in is sampled in the clk_48 cycle where bclk toggles 0->1.
  - Bits at pos 1..DATA_WIDTH shift into the left or right receive register, selected by the current i2s_lr.
- Receive completion:
  - On the rising edge that samples right-slot pos DATA_WIDTH (LSB), rx_l and rx_r update together from the receive registers in that cycle.
  - rx_valid pulses for that cycle.
  - A frame whose left slot was not fully received (started mid-frame) does not assert rx_valid.
- Start-up from idle:
  - The first falling edge of the first frame occurs HALF_BCLK cycles after enable is first seen high with bclk=1 pending. Concretely: the first rising edge comes after HALF_BCLK cycles and the first falling edge after 2*HALF_BCLK cycles.
  - That first falling edge is frame start.
- enable deasserted mid-frame:
  - The current frame completes, including rx_valid.
  - After bit_cnt=2*SLOT_BITS-1, the block stops at bclk=0 and lr=1, with half_cnt held at 0.
  - Re-assertion resumes at a frame start.
- reset mid-frame: immediate return to reset values. The partial frame is discarded and no rx_valid is produced.
- Reset has priority over enable. Simultaneous sample_req and rx_valid cannot occur with legal parameters; no special case is required.

Test Plan:
- Reset then enable=1, HALF_BCLK=8 -> bclk period 16 cycles, lr period 1024 cycles, first sample_req at cycle 16 after enable, then every 1024 cycles.
- tx_l=0xABCDEF, tx_r=0x123456 -> sdata_out at left pos 1..24 = 0xABCDEF MSB first, right pos 1..24 = 0x123456; pos 0 and 25..31 are 0; bits change only on falling edges.
- Loopback sdata_out->sdata_in with a new tx pair each frame -> each rx_valid shows rx_l/rx_r equal to the pair loaded at the preceding sample_req, one frame latency, no skipped frames.
- tx_l changed to 0x000001 at mid left slot -> the current frame still transmits the old value; the next frame transmits 0x000001.
- enable dropped at bit_cnt=10 -> the frame completes with rx_valid; bclk then stays 0 and lr stays 1; re-enable -> sample_req after 16 cycles.
- reset pulsed at bit_cnt=40 -> all outputs at reset values the next cycle, no rx_valid; after release, a clean frame produces correct data.

Source files
------------

// File: rtl/i2s_codec_master.sv
// I2S codec-side master: divides clk_48 into BCLK/LRCLK, shifts tx samples out, captures rx samples.
// Outputs registered; rx pair lands at the right-slot LSB rising edge; no backpressure, tx sampled at frame start.
module i2s_codec_master #(
  parameter int HALF_BCLK  = 8,
  parameter int DATA_WIDTH = 24,
  parameter int SLOT_BITS  = 32
) (
  input  logic                  clk_48_i,
  input  logic                  reset_i,
  input  logic                  enable_i,
  input  logic [DATA_WIDTH-1:0] tx_l_i,
  input  logic [DATA_WIDTH-1:0] tx_r_i,
  output logic                  sample_req_o,
  output logic [DATA_WIDTH-1:0] rx_l_o,
  output logic [DATA_WIDTH-1:0] rx_r_o,
  output logic                  rx_valid_o,
  output logic                  i2s_bclk_o,
  output logic                  i2s_lr_o,
  output logic                  i2s_sdata_out_o,
  input  logic                  i2s_sdata_in_i
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int CW         = $clog2(FRAME_BITS);
  localparam int HW         = $clog2(HALF_BCLK);

  localparam logic [HW-1:0] HALF_LAST  = HW'(HALF_BCLK - 1);
  localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_BITS - 1);
  localparam logic [CW-1:0] SLOT_W     = CW'(SLOT_BITS);
  localparam logic [CW-1:0] DATA_W     = CW'(DATA_WIDTH);

  logic [HW-1:0]         half_cnt_q, half_cnt_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  bclk_q, bclk_d;
  logic                  lr_q, lr_d;
  logic                  sdata_out_q, sdata_out_d;
  logic                  sample_req_q, sample_req_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  armed_q, armed_d;
  logic [DATA_WIDTH-1:0] tx_sh_l_q, tx_sh_l_d;
  logic [DATA_WIDTH-1:0] tx_sh_r_q, tx_sh_r_d;
  logic [DATA_WIDTH-1:0] rx_sh_l_q, rx_sh_l_d;
  logic [DATA_WIDTH-1:0] rx_sh_r_q, rx_sh_r_d;
  logic [DATA_WIDTH-1:0] rx_l_q, rx_l_d;
  logic [DATA_WIDTH-1:0] rx_r_q, rx_r_d;

  logic          idle, run, tick, rise, fall, frame_start;
  logic [CW-1:0] bit_cnt_nxt, nxt_pos, cur_pos;
  logic          nxt_lr, nxt_data, cur_data;

  // Idle is the parked end-of-frame state; the clocks keep running until a
  // frame finishes, so dropping enable never truncates a frame.
  always_comb begin
    idle        = (bit_cnt_q == FRAME_LAST) && !bclk_q && (half_cnt_q == '0);
    run         = enable_i || !idle;
    tick        = run && (half_cnt_q == HALF_LAST);
    rise        = tick && !bclk_q;
    fall        = tick && bclk_q;
    bit_cnt_nxt = (bit_cnt_q == FRAME_LAST) ? '0 : bit_cnt_q + 1'b1;
    frame_start = fall && (bit_cnt_q == FRAME_LAST);
    nxt_lr      = (bit_cnt_nxt >= SLOT_W);
    nxt_pos     = nxt_lr ? (bit_cnt_nxt - SLOT_W) : bit_cnt_nxt;
    nxt_data    = (nxt_pos >= CW'(1)) && (nxt_pos <= DATA_W);
    cur_pos     = lr_q ? (bit_cnt_q - SLOT_W) : bit_cnt_q;
    cur_data    = (cur_pos >= CW'(1)) && (cur_pos <= DATA_W);
  end

  always_comb begin
    half_cnt_d   = half_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    bclk_d       = bclk_q;
    lr_d         = lr_q;
    sdata_out_d  = sdata_out_q;
    sample_req_d = 1'b0;
    rx_valid_d   = 1'b0;
    armed_d      = armed_q;
    tx_sh_l_d    = tx_sh_l_q;
    tx_sh_r_d    = tx_sh_r_q;
    rx_sh_l_d    = rx_sh_l_q;
    rx_sh_r_d    = rx_sh_r_q;
    rx_l_d       = rx_l_q;
    rx_r_d       = rx_r_q;

    if (run) begin
      half_cnt_d = (half_cnt_q == HALF_LAST) ? '0 : half_cnt_q + 1'b1;
    end
    if (tick) begin
      bclk_d = !bclk_q;
    end

    // Falling edge: advance slot position and present the next data bit
    // (one BCLK after the LR transition).
    if (fall) begin
      bit_cnt_d   = bit_cnt_nxt;
      lr_d        = nxt_lr;
      sdata_out_d = 1'b0;
      if (frame_start) begin
        tx_sh_l_d    = tx_l_i;
        tx_sh_r_d    = tx_r_i;
        sample_req_d = 1'b1;
        armed_d      = 1'b1;
      end else if (nxt_data) begin
        if (nxt_lr) begin
          {sdata_out_d, tx_sh_r_d} = {tx_sh_r_q, 1'b0};
        end else begin
          {sdata_out_d, tx_sh_l_d} = {tx_sh_l_q, 1'b0};
        end
      end
    end

    if (rise && cur_data) begin
      if (lr_q) begin
        rx_sh_r_d = {rx_sh_r_q[DATA_WIDTH-2:0], i2s_sdata_in_i};
        if (cur_pos == DATA_W) begin
          rx_l_d     = rx_sh_l_q;
          rx_r_d     = rx_sh_r_d;
          rx_valid_d = armed_q;
        end
      end else begin
        rx_sh_l_d = {rx_sh_l_q[DATA_WIDTH-2:0], i2s_sdata_in_i};
      end
    end
  end

  always_ff @(posedge clk_48_i) begin
    if (reset_i) begin
      half_cnt_q   <= '0;
      bit_cnt_q    <= FRAME_LAST;
      bclk_q       <= 1'b0;
      lr_q         <= 1'b1;
      sdata_out_q  <= 1'b0;
      sample_req_q <= 1'b0;
      rx_valid_q   <= 1'b0;
      armed_q      <= 1'b0;
      tx_sh_l_q    <= '0;
      tx_sh_r_q    <= '0;
      rx_sh_l_q    <= '0;
      rx_sh_r_q    <= '0;
      rx_l_q       <= '0;
      rx_r_q       <= '0;
    end else begin
      half_cnt_q   <= half_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      bclk_q       <= bclk_d;
      lr_q         <= lr_d;
      sdata_out_q  <= sdata_out_d;
      sample_req_q <= sample_req_d;
      rx_valid_q   <= rx_valid_d;
      armed_q      <= armed_d;
      tx_sh_l_q    <= tx_sh_l_d;
      tx_sh_r_q    <= tx_sh_r_d;
      rx_sh_l_q    <= rx_sh_l_d;
      rx_sh_r_q    <= rx_sh_r_d;
      rx_l_q       <= rx_l_d;
      rx_r_q       <= rx_r_d;
    end
  end

  assign sample_req_o    = sample_req_q;
  assign rx_valid_o      = rx_valid_q;
  assign rx_l_o          = rx_l_q;
  assign rx_r_o          = rx_r_q;
  assign i2s_bclk_o      = bclk_q;
  assign i2s_lr_o        = lr_q;
  assign i2s_sdata_out_o = sdata_out_q;

endmodule

// File: tb/tb_i2s_codec_master.sv
// Directed bench for i2s_codec_master with serial loopback (sdata_out -> sdata_in).
module tb_i2s_codec_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [23:0] tx_l, tx_r;
  logic        sample_req, rx_valid;
  logic [23:0] rx_l, rx_r;
  logic        bclk, lr, sdata_out;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  i2s_codec_master #(.HALF_BCLK(8), .DATA_WIDTH(24), .SLOT_BITS(32)) dut (
    .clk_48_i        (clk),
    .reset_i         (reset),
    .enable_i        (enable),
    .tx_l_i          (tx_l),
    .tx_r_i          (tx_r),
    .sample_req_o    (sample_req),
    .rx_l_o          (rx_l),
    .rx_r_o          (rx_r),
    .rx_valid_o      (rx_valid),
    .i2s_bclk_o      (bclk),
    .i2s_lr_o        (lr),
    .i2s_sdata_out_o (sdata_out),
    .i2s_sdata_in_i  (sdata_out)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_frame(input logic [23:0] l, input logic [23:0] r);
    logic [63:0] e;
    e = '0;
    for (int p = 1; p <= 24; p++) begin
      e[p]      = l[24-p];
      e[32 + p] = r[24-p];
    end
    return e;
  endfunction

  // Observes one 1024-cycle frame starting at the sample_req cycle.
  task automatic run_frame(input int chg_at, input logic [23:0] nl, input logic [23:0] nr,
                           input int drop_at,
                           output logic [63:0] bits, output int glitch, output int clkerr,
                           output int midreq, output int nvalid, output int vat,
                           output logic [23:0] rl, output logic [23:0] rr);
    logic prev_b, prev_d, expb;
    bits = '0; glitch = 0; clkerr = 0; midreq = 0; nvalid = 0; vat = -1;
    rl = '0; rr = '0;
    prev_b = bclk; prev_d = sdata_out;
    for (int c = 0; c < 1024; c++) begin
      if (c > 0) begin
        if (sdata_out !== prev_d && !(prev_b === 1'b1 && bclk === 1'b0)) glitch++;
        if (sample_req !== 1'b0) midreq++;
      end
      expb = (c % 16 >= 8) && !(drop_at >= 0 && c >= 1008);
      if (bclk !== expb || lr !== (c >= 512)) clkerr++;
      if (c % 16 == 8) bits[c/16] = sdata_out;
      if (rx_valid === 1'b1) begin
        nvalid++; vat = c; rl = rx_l; rr = rx_r;
      end
      if (c == chg_at) begin tx_l = nl; tx_r = nr; end
      if (c == drop_at) enable = 1'b0;
      prev_b = bclk; prev_d = sdata_out;
      tick(1);
    end
  endtask

  task automatic check_frame(input string tag, input logic [63:0] bits, input logic [23:0] el,
                             input logic [23:0] er, input int glitch, input int clkerr,
                             input int midreq, input int nvalid, input int vat,
                             input logic [23:0] rl, input logic [23:0] rr);
    chk({tag, "_bits"}, bits, exp_frame(el, er));
    chk({tag, "_glitch"}, 64'(glitch), 64'd0);
    chk({tag, "_clk_lr"}, 64'(clkerr), 64'd0);
    chk({tag, "_midreq"}, 64'(midreq), 64'd0);
    chk({tag, "_nvalid"}, 64'(nvalid), 64'd1);
    chk({tag, "_valid_at"}, 64'(vat), 64'd904);
    chk({tag, "_rx_l"}, 64'(rl), 64'(el));
    chk({tag, "_rx_r"}, 64'(rr), 64'(er));
  endtask

  initial begin
    logic [63:0] bits;
    logic [23:0] rl, rr;
    int glitch, clkerr, midreq, nvalid, vat;

    reset = 1'b1; enable = 1'b0; tx_l = 24'hABCDEF; tx_r = 24'h123456;
    tick(3);
    chk("rst_bclk", 64'(bclk), 64'd0);
    chk("rst_lr", 64'(lr), 64'd1);
    chk("rst_sdata", 64'(sdata_out), 64'd0);
    chk("rst_req", 64'(sample_req), 64'd0);
    chk("rst_valid", 64'(rx_valid), 64'd0);
    chk("rst_rx", {16'd0, rx_l, rx_r}, 64'd0);
    reset = 1'b0;
    tick(5);
    chk("idle_bclk", 64'(bclk), 64'd0);

    // Start-up: rise after 8 cycles, fall (frame start) after 16.
    enable = 1'b1;
    tick(7);
    chk("start_bclk_lo", 64'(bclk), 64'd0);
    tick(1);
    chk("start_bclk_hi", 64'(bclk), 64'd1);
    tick(7);
    chk("start_req_early", 64'(sample_req), 64'd0);
    tick(1);
    chk("start_req", 64'(sample_req), 64'd1);
    chk("start_lr", 64'(lr), 64'd0);

    // Frame 1: tx_l changes to 1 mid left slot, must not disturb this frame.
    run_frame(256, 24'h000001, 24'h123456, -1, bits, glitch, clkerr, midreq, nvalid, vat, rl, rr);
    check_frame("f1", bits, 24'hABCDEF, 24'h123456, glitch, clkerr, midreq, nvalid, vat, rl, rr);
    chk("f1_next_req", 64'(sample_req), 64'd1);

    run_frame(300, 24'h5A5A5A, 24'hC3C3C3, -1, bits, glitch, clkerr, midreq, nvalid, vat, rl, rr);
    check_frame("f2", bits, 24'h000001, 24'h123456, glitch, clkerr, midreq, nvalid, vat, rl, rr);
    chk("f2_next_req", 64'(sample_req), 64'd1);

    run_frame(5, 24'hFFFFFF, 24'h800001, -1, bits, glitch, clkerr, midreq, nvalid, vat, rl, rr);
    check_frame("f3", bits, 24'h5A5A5A, 24'hC3C3C3, glitch, clkerr, midreq, nvalid, vat, rl, rr);
    chk("f3_next_req", 64'(sample_req), 64'd1);

    // Frame 4: enable dropped at bit 10; frame completes, then parks.
    run_frame(-1, 24'h0, 24'h0, 160, bits, glitch, clkerr, midreq, nvalid, vat, rl, rr);
    check_frame("f4", bits, 24'hFFFFFF, 24'h800001, glitch, clkerr, midreq, nvalid, vat, rl, rr);
    chk("stop_req", 64'(sample_req), 64'd0);
    tick(50);
    chk("stop_bclk", 64'(bclk), 64'd0);
    chk("stop_lr", 64'(lr), 64'd1);
    chk("stop_sdata", 64'(sdata_out), 64'd0);

    tx_l = 24'h13579B; tx_r = 24'h2468AC;
    enable = 1'b1;
    tick(15);
    chk("reen_req_early", 64'(sample_req), 64'd0);
    tick(1);
    chk("reen_req", 64'(sample_req), 64'd1);

    // Reset pulse during bit 40.
    tick(645);
    reset = 1'b1;
    tick(1);
    chk("mid_rst_bclk", 64'(bclk), 64'd0);
    chk("mid_rst_lr", 64'(lr), 64'd1);
    chk("mid_rst_sdata", 64'(sdata_out), 64'd0);
    chk("mid_rst_valid", 64'(rx_valid), 64'd0);
    chk("mid_rst_rx", {16'd0, rx_l, rx_r}, 64'd0);
    tx_l = 24'h0F0F0F; tx_r = 24'hF0F0F0;
    reset = 1'b0;
    tick(15);
    chk("post_rst_req_early", 64'(sample_req), 64'd0);
    tick(1);
    chk("post_rst_req", 64'(sample_req), 64'd1);

    run_frame(-1, 24'h0, 24'h0, -1, bits, glitch, clkerr, midreq, nvalid, vat, rl, rr);
    check_frame("f6", bits, 24'h0F0F0F, 24'hF0F0F0, glitch, clkerr, midreq, nvalid, vat, rl, rr);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
